alu_pipe: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_cla_group.sv | 30 +++
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_alu_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM states and decode helpers for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_e;

    // Ops that run the adder as a + ~b + 1
    function automatic logic op_inverts_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response handshake bundle between operand fetch, ALU and writeback.
interface alu_pipe_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             op_err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero, negative, op_err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero, negative, op_err
    );

endinterface

// File: rtl/alu_cla_group.sv
// 4-bit carry-lookahead slice: sum plus group generate/propagate for the
// inter-group carry chain, and the carry into bit 3 for overflow detection.
module alu_cla_group (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       g_o,
    output logic       p_o,
    output logic       c3_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

    assign sum_o = p ^ c;
    assign g_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign p_o   = &p;
    assign c3_o  = c[3];

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; single-cycle logic/arith ops and
// an iterative shift-add multiply that holds off new requests while it runs.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    import alu_pkg::*;

    localparam int NG = WIDTH / 4;
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nxt;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   result_q, b_eff, sum, res_d, wr_res;
    logic               out_valid_q, cout_q, ovf_q, zero_q, neg_q, err_q;
    logic               cout_d, ovf_d, err_d, wr_cout, wr_ovf, wr_err;
    logic               sub_mode, add_cout, add_ovf, c_msb;
    logic [NG:0]        gc;
    logic [NG-1:0]      gg, gp;
    logic               in_ready, accept, is_mul, start_mul, mul_done;

    // Adder: cascade of CLA groups, group carries rippled via g/p
    assign sub_mode = op_inverts_b(bus.op);
    assign b_eff    = sub_mode ? ~bus.b : bus.b;
    assign gc[0]    = sub_mode;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        if (k == NG - 1) begin : g_top
            alu_cla_group u_grp (
                .a_i(bus.a[4*k +: 4]), .b_i(b_eff[4*k +: 4]), .cin_i(gc[k]),
                .sum_o(sum[4*k +: 4]), .g_o(gg[k]), .p_o(gp[k]), .c3_o(c_msb)
            );
        end else begin : g_low
            logic c3_unused;
            alu_cla_group u_grp (
                .a_i(bus.a[4*k +: 4]), .b_i(b_eff[4*k +: 4]), .cin_i(gc[k]),
                .sum_o(sum[4*k +: 4]), .g_o(gg[k]), .p_o(gp[k]), .c3_o(c3_unused)
            );
        end
        assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    assign add_cout = gc[NG];
    assign add_ovf  = c_msb ^ add_cout;

    // Handshake decode
    assign is_mul    = MUL_EN && (bus.op == OP_MUL);
    assign accept    = bus.in_valid & in_ready;
    assign start_mul = accept & is_mul;
    assign mul_done  = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH - 1));
    assign acc_nxt   = mplier_q[0] ? acc_q + mcand_q : acc_q;

    // Single-cycle result and flag selection
    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        err_d  = 1'b0;
        case (bus.op)
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_NOR:  res_d = ~(bus.a | bus.b);
            OP_ADD, OP_SUB: begin
                res_d  = sum;
                cout_d = add_cout;
                ovf_d  = add_ovf;
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, ~add_cout};
            default: err_d = 1'b1;
        endcase
    end

    // Output register write data: multiply completion or single-cycle op
    always_comb begin
        wr_res  = res_d;
        wr_cout = cout_d;
        wr_ovf  = ovf_d;
        wr_err  = err_d;
        if (mul_done) begin
            wr_res  = acc_nxt[WIDTH-1:0];
            wr_cout = 1'b0;
            wr_ovf  = |acc_nxt[2*WIDTH-1:WIDTH];
            wr_err  = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mul) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output: accept only when idle and the output register is free or draining
    always_comb begin
        in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    end

    // Multiply datapath: shift-add, one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == ST_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nxt;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // Output register: load on single-cycle accept or multiply finish, clear on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if ((accept && !is_mul) || mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= wr_res;
            cout_q      <= wr_cout;
            ovf_q       <= wr_ovf;
            zero_q      <= (wr_res == '0);
            neg_q       <= wr_res[WIDTH-1];
            err_q       <= wr_err;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.op_err    = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised bench for alu_pipe: scoreboard against an arithmetic reference,
// plus directed boundary cases and an 8-bit instance without the multiplier.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         cout, ovf, zero, neg, err;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];

    logic rnd_rdy = 1'b0;
    logic rnd_val = 1'b1;
    logic man_rdy = 1'b1;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe_if #(.WIDTH(8)) bus8 ();

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.out_ready  = rnd_rdy ? rnd_val : man_rdy;
    assign bus8.out_ready = 1'b1;

    always @(posedge clk) begin
        #2;
        rnd_val = ($urandom % 4) != 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pk(input logic [W-1:0] r, input logic c, o, z, n, e);
        return {27'b0, e, n, z, o, c, r};
    endfunction

    // Reference: results straight from wide arithmetic and signed/unsigned compares
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        e = '{res: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0, err: 1'b0, due: 0};
        case (op)
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_NOR:  e.res = ~(a | b);
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.cout = s[W];
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                e.res = a - b;
                e.cout = (a >= b);
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SLTU: e.res = (a < b) ? 1 : 0;
            default: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.ovf = p[2*W-1:W] != 0;
            end
        endcase
        e.zero = (e.res == 0);
        e.neg  = e.res[W-1];
        return e;
    endfunction

    // Compare process: every cycle, DUT outputs vs the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (!rst_n) begin
            q.delete();
            chk("reset_state", {bus.out_valid, bus.in_ready, bus.cout, bus.overflow, bus.zero,
                                bus.negative, bus.op_err, bus.result}, 64'd0);
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].due);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_v});
            if (exp_v && bus.out_valid) begin
                chk("out_data", pk(bus.result, bus.cout, bus.overflow, bus.zero, bus.negative, bus.op_err),
                    pk(q[0].res, q[0].cout, q[0].ovf, q[0].zero, q[0].neg, q[0].err));
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.op, bus.a, bus.b);
                e.due = cyc + ((bus.op == OP_MUL) ? W + 1 : 1);
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", {63'd0, q.size() != 0}, 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return ($urandom % 2) ? $urandom : W'($urandom % 256);
        endcase
    endfunction

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.in_valid = 1'b0; bus.op = OP_AND; bus.a = '0; bus.b = '0;
        bus8.in_valid = 1'b0; bus8.op = OP_AND; bus8.a = '0; bus8.b = '0;

        // Pin the reference model with hand-computed values
        e = model(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        chk("pin_add_ovf", pk(e.res, e.cout, e.ovf, e.zero, e.neg, e.err), pk(32'h8000_0000, 0, 1, 0, 1, 0));
        e = model(OP_SUB, 32'd5, 32'd5);
        chk("pin_sub_zero", pk(e.res, e.cout, e.ovf, e.zero, e.neg, e.err), pk(32'd0, 1, 0, 1, 0, 0));
        e = model(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("pin_slt", {32'd0, e.res}, 64'd1);
        e = model(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk("pin_sltu", {32'd0, e.res}, 64'd0);
        e = model(OP_MUL, 32'h1_0000, 32'h1_0000);
        chk("pin_mul_ovf", pk(e.res, e.cout, e.ovf, e.zero, e.neg, e.err), pk(32'd0, 0, 1, 1, 0, 0));
        e = model(OP_MUL, 32'd3, 32'd7);
        chk("pin_mul_small", pk(e.res, e.cout, e.ovf, e.zero, e.neg, e.err), pk(32'd21, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        chk("reset_w8", {bus8.out_valid, bus8.in_ready, bus8.op_err, bus8.zero, 24'd0, bus8.result}, 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed boundary ops
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        send(OP_SUB, 32'd5, 32'd5);
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        drain();

        // Multiply: busy for the whole run, result lands WIDTH edges after accept
        send(OP_MUL, 32'h1_0000, 32'h1_0000);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(negedge clk);
        chk("mul_done_result", {31'd0, bus.out_valid, bus.result}, {31'd1, 32'd0});
        @(posedge clk); #1;
        send(OP_MUL, 32'd3, 32'd7);
        drain();

        // Backpressure: result held, no new accepts, then back-to-back
        man_rdy = 1'b0;
        send(OP_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_hold", {31'd0, bus.out_valid, bus.result}, {31'd1, 32'd3});
        end
        @(posedge clk); #1;
        man_rdy = 1'b1;
        send(OP_OR, 32'hF0, 32'h0F);
        send(OP_NOR, 32'h0, 32'h0);
        send(OP_SUB, 32'd1, 32'd2);
        drain();

        // Reset during a multiply discards it
        send(OP_MUL, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_mul", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (W + 5) begin @(posedge clk); #1; end
        send(OP_ADD, 32'd2, 32'd2);
        @(negedge clk);
        chk("post_rst_add", {31'd0, bus.out_valid, bus.result}, {31'd1, 32'd4});
        drain();

        // Randomised traffic with random output backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(3'($urandom % 8), pick(), pick());
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
        drain();
        rnd_rdy = 1'b0;

        // 8-bit instance without multiplier: MUL is illegal
        bus8.op = OP_MUL; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.in_valid = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", {63'd0, bus8.in_ready}, 64'd1);
        @(posedge clk); #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("w8_illegal", {50'd0, bus8.out_valid, bus8.op_err, bus8.zero, bus8.negative,
                           bus8.overflow, bus8.cout, bus8.result}, {50'd0, 6'b111000, 8'h00});
        bus8.op = OP_AND; bus8.a = 8'hF0; bus8.b = 8'h3C; bus8.in_valid = 1'b1;
        @(posedge clk); #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("w8_and", {50'd0, bus8.out_valid, bus8.op_err, bus8.zero, bus8.negative,
                       bus8.overflow, bus8.cout, bus8.result}, {50'd0, 6'b100000, 8'h30});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
